// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory requests,
// in-order response buffering toward decode, and redirect with stale-response dropping.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]  DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] pcq_wr, pcq_rd;
    logic [AW-1:0] fq_wr, fq_rd;

    logic [31:0] pcq_mem  [DEPTH];
    logic [31:0] fq_instr [DEPTH];
    logic [31:0] fq_pc    [DEPTH];

    logic [CW:0]  credit_used;
    logic [31:0]  target_pc;
    logic         req_fire, rsp_fire, rsp_keep, dec_fire;

    // Buffered plus outstanding entries never exceed DEPTH, so a returning response always has room.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign target_pc      = redirect_pc & 32'hFFFF_FFFC;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_fire && !redirect && (drop == '0);
    assign dec_fire = dec_valid && dec_ready;

    assign dec_valid    = (fifo_count != '0);
    assign dec_instr    = dec_valid ? fq_instr[fq_rd] : NOP;
    assign dec_pc       = dec_valid ? fq_pc[fq_rd] : 32'h0;
    assign dec_pc_plus4 = dec_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            inflight   <= '0;
            drop       <= '0;
            fifo_count <= '0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
            fq_wr      <= '0;
            fq_rd      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcq_wr   <= pcq_wr + AW'(1);
            end
            if (rsp_fire) begin
                pcq_rd <= pcq_rd + AW'(1);
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);

            if (redirect) begin
                // Everything still outstanding after this cycle's response belongs to the old path.
                fetch_pc   <= target_pc;
                drop       <= inflight - CW'(rsp_fire);
                fifo_count <= '0;
                fq_rd      <= fq_wr;
            end else begin
                if (rsp_fire && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (rsp_keep) begin
                    fq_wr <= fq_wr + AW'(1);
                end
                if (dec_fire) begin
                    fq_rd <= fq_rd + AW'(1);
                end
                fifo_count <= fifo_count + CW'(rsp_keep) - CW'(dec_fire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
        if (rsp_keep) begin
            fq_instr[fq_wr] <= imem_rsp_data;
            fq_pc[fq_wr]    <= pcq_mem[pcq_rd];
        end
    end
endmodule
